write_to_ddr3: RTL and testbench

//  Ping-pong frame writer feeding the DDR3 read path. Drains 128-bit pixel words (4x32-bit px) from a show-ahead

---
 rtl/write_to_ddr3.sv | 194 +++++++++++++++++++
 tb/tb_write_to_ddr3.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_to_ddr3.sv
// Ping-pong frame writer: drains 128-bit pixel words from a show-ahead FIFO and writes whole frames
// as Avalon-MM bursts into DDR3 buffer 0 or 1, flagging each buffer valid once its frame is complete.
module write_to_ddr3 #(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 1024,
    parameter int BURST_LEN    = 4,
    parameter int USEDW_W      = 9
) (
    input  logic               ddr3_clk,
    input  logic               ddr3_reset_n,
    input  logic               enable,
    input  logic [25:0]        buffer0_offset,
    input  logic [25:0]        buffer1_offset,
    input  logic               clear_buffer0,
    input  logic               clear_buffer1,
    output logic               buffer0_valid,
    output logic               buffer1_valid,
    output logic               frame_done,
    input  logic [127:0]       src_fifo_rd_data,
    input  logic [USEDW_W-1:0] src_fifo_usedw,
    output logic               src_fifo_rd,
    input  logic               ddr3_avl_ready,
    output logic               ddr3_avl_burstbegin,
    output logic               ddr3_avl_write_req,
    output logic [25:0]        ddr3_avl_addr,
    output logic [2:0]         ddr3_avl_size,
    output logic [127:0]       ddr3_avl_wdata,
    output logic [15:0]        ddr3_avl_be
);

    localparam int WORDS  = (IMAGE_WIDTH * IMAGE_HEIGHT) >> 2;
    localparam int BURSTS = WORDS / BURST_LEN;
    localparam int BCNT_W = (BURSTS > 1) ? $clog2(BURSTS) : 1;

    localparam logic [2:0]         BURST_SIZE = 3'(BURST_LEN);
    localparam logic [2:0]         LAST_BEAT  = 3'(BURST_LEN - 1);
    localparam logic [BCNT_W-1:0]  LAST_BURST = BCNT_W'(BURSTS - 1);
    localparam logic [USEDW_W-1:0] MIN_USEDW  = USEDW_W'(BURST_LEN);
    localparam logic [25:0]        ADDR_STEP  = 26'(BURST_LEN);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_DATA  = 2'd1,
        ST_BURST      = 2'd2,
        ST_FRAME_DONE = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic               wr_sel_r, wr_sel_s;
    logic               valid0_r, valid0_s;
    logic               valid1_r, valid1_s;
    logic               burstbegin_r, burstbegin_s;
    logic               write_req_r, write_req_s;
    logic               frame_done_r, frame_done_s;
    logic [25:0]        addr_r, addr_s;
    logic [2:0]         size_r, size_s;
    logic [2:0]         beat_cnt_r, beat_cnt_s;
    logic [BCNT_W-1:0]  burst_cnt_r, burst_cnt_s;
    logic               set0_s, set1_s;
    logic               cur_valid_s;
    logic               beat_accept_s;

    assign beat_accept_s       = write_req_r & ddr3_avl_ready;
    assign cur_valid_s         = wr_sel_r ? valid1_r : valid0_r;

    assign src_fifo_rd         = beat_accept_s;
    assign ddr3_avl_wdata      = src_fifo_rd_data;
    assign ddr3_avl_be         = 16'hFFFF;
    assign ddr3_avl_burstbegin = burstbegin_r;
    assign ddr3_avl_write_req  = write_req_r;
    assign ddr3_avl_addr       = addr_r;
    assign ddr3_avl_size       = size_r;
    assign frame_done          = frame_done_r;
    assign buffer0_valid       = valid0_r;
    assign buffer1_valid       = valid1_r;

    // Next-state and next-register values for the frame writer.
    always_comb begin
        state_s      = state_r;
        wr_sel_s     = wr_sel_r;
        burstbegin_s = burstbegin_r;
        write_req_s  = write_req_r;
        frame_done_s = 1'b0;
        addr_s       = addr_r;
        size_s       = size_r;
        beat_cnt_s   = beat_cnt_r;
        burst_cnt_s  = burst_cnt_r;
        set0_s       = 1'b0;
        set1_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // A still-valid target buffer means the reader lags: hold rather than overwrite or skip.
                if (enable && !cur_valid_s) begin
                    addr_s      = wr_sel_r ? buffer1_offset : buffer0_offset;
                    size_s      = BURST_SIZE;
                    beat_cnt_s  = 3'd0;
                    burst_cnt_s = '0;
                    state_s     = ST_WAIT_DATA;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                if (src_fifo_usedw >= MIN_USEDW) begin
                    burstbegin_s = 1'b1;
                    write_req_s  = 1'b1;
                    state_s      = ST_BURST;
                end else begin
                    state_s = ST_WAIT_DATA;
                end
            end
            ST_BURST: begin
                if (beat_accept_s) begin
                    burstbegin_s = 1'b0;
                    if (beat_cnt_r == LAST_BEAT) begin
                        write_req_s = 1'b0;
                        beat_cnt_s  = 3'd0;
                        if (burst_cnt_r == LAST_BURST) begin
                            frame_done_s = 1'b1;
                            state_s      = ST_FRAME_DONE;
                        end else begin
                            addr_s      = addr_r + ADDR_STEP;
                            burst_cnt_s = burst_cnt_r + BCNT_W'(1);
                            state_s     = ST_WAIT_DATA;
                        end
                    end else begin
                        beat_cnt_s = beat_cnt_r + 3'd1;
                    end
                end else begin
                    state_s = ST_BURST;
                end
            end
            ST_FRAME_DONE: begin
                if (wr_sel_r) begin
                    set1_s = 1'b1;
                end else begin
                    set0_s = 1'b1;
                end
                wr_sel_s = ~wr_sel_r;
                state_s  = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Completion beats a simultaneous reader clear so a fresh frame is never lost.
        if (set0_s) begin
            valid0_s = 1'b1;
        end else if (clear_buffer0) begin
            valid0_s = 1'b0;
        end else begin
            valid0_s = valid0_r;
        end
        if (set1_s) begin
            valid1_s = 1'b1;
        end else if (clear_buffer1) begin
            valid1_s = 1'b0;
        end else begin
            valid1_s = valid1_r;
        end
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            state_r      <= ST_IDLE;
            wr_sel_r     <= 1'b0;
            valid0_r     <= 1'b0;
            valid1_r     <= 1'b0;
            burstbegin_r <= 1'b0;
            write_req_r  <= 1'b0;
            frame_done_r <= 1'b0;
            addr_r       <= 26'd0;
            size_r       <= 3'd0;
            beat_cnt_r   <= 3'd0;
            burst_cnt_r  <= '0;
        end else begin
            state_r      <= state_s;
            wr_sel_r     <= wr_sel_s;
            valid0_r     <= valid0_s;
            valid1_r     <= valid1_s;
            burstbegin_r <= burstbegin_s;
            write_req_r  <= write_req_s;
            frame_done_r <= frame_done_s;
            addr_r       <= addr_s;
            size_r       <= size_s;
            beat_cnt_r   <= beat_cnt_s;
            burst_cnt_r  <= burst_cnt_s;
        end
    end

endmodule

// File: tb/tb_write_to_ddr3.sv
// Bench for write_to_ddr3 with an 8x2 image (4 words, 2 bursts of 2): a FIFO model feeds the DUT and a
// transaction-level scoreboard predicts addresses, data order, burst markers, frame pulses and buffer flags.
module tb_write_to_ddr3;

    logic         ddr3_clk;
    logic         ddr3_reset_n;
    logic         enable;
    logic [25:0]  buffer0_offset;
    logic [25:0]  buffer1_offset;
    logic         clear_buffer0;
    logic         clear_buffer1;
    logic         buffer0_valid;
    logic         buffer1_valid;
    logic         frame_done;
    logic [127:0] src_fifo_rd_data;
    logic [8:0]   src_fifo_usedw;
    logic         src_fifo_rd;
    logic         ddr3_avl_ready;
    logic         ddr3_avl_burstbegin;
    logic         ddr3_avl_write_req;
    logic [25:0]  ddr3_avl_addr;
    logic [2:0]   ddr3_avl_size;
    logic [127:0] ddr3_avl_wdata;
    logic [15:0]  ddr3_avl_be;

    write_to_ddr3 #(
        .IMAGE_WIDTH (8),
        .IMAGE_HEIGHT(2),
        .BURST_LEN   (2),
        .USEDW_W     (9)
    ) dut (
        .ddr3_clk           (ddr3_clk),
        .ddr3_reset_n       (ddr3_reset_n),
        .enable             (enable),
        .buffer0_offset     (buffer0_offset),
        .buffer1_offset     (buffer1_offset),
        .clear_buffer0      (clear_buffer0),
        .clear_buffer1      (clear_buffer1),
        .buffer0_valid      (buffer0_valid),
        .buffer1_valid      (buffer1_valid),
        .frame_done         (frame_done),
        .src_fifo_rd_data   (src_fifo_rd_data),
        .src_fifo_usedw     (src_fifo_usedw),
        .src_fifo_rd        (src_fifo_rd),
        .ddr3_avl_ready     (ddr3_avl_ready),
        .ddr3_avl_burstbegin(ddr3_avl_burstbegin),
        .ddr3_avl_write_req (ddr3_avl_write_req),
        .ddr3_avl_addr      (ddr3_avl_addr),
        .ddr3_avl_size      (ddr3_avl_size),
        .ddr3_avl_wdata     (ddr3_avl_wdata),
        .ddr3_avl_be        (ddr3_avl_be)
    );

    initial begin
        ddr3_clk = 1'b0;
        forever #5 ddr3_clk = ~ddr3_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] fifo_q[$];
    logic [127:0] exp_q[$];
    logic [25:0]  addr_log[$];
    int           usedw_force = -1;
    logic         pop_pending = 1'b0;
    int           pix = 0;

    logic [1:0]   mdl_valid = 2'b00;
    int           mdl_buf = 0, mdl_burst = 0, mdl_beat = 0;
    logic         fd_pending = 1'b0;
    int           frames_seen = 0, wr_req_cycles = 0, beats_accepted = 0;

    logic         prev_stall = 1'b0;
    logic [25:0]  prev_addr;
    logic [2:0]   prev_size;
    logic [127:0] prev_wdata;
    logic         prev_bb;
    logic         fd_now;
    logic [1:0]   nv;
    logic [127:0] exp_word;
    logic [25:0]  exp_addr;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void refresh();
        src_fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 128'd0;
        src_fifo_usedw   = (usedw_force >= 0) ? 9'(usedw_force) : 9'(fifo_q.size());
    endfunction

    task automatic push_words(input int n);
        logic [127:0] w;
        for (int i = 0; i < n; i++) begin
            w = {32'(pix + 3), 32'(pix + 2), 32'(pix + 1), 32'(pix)};
            pix += 4;
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        refresh();
    endtask

    task automatic pulse_clear(input int b);
        @(negedge ddr3_clk);
        if (b == 0) clear_buffer0 = 1'b1; else clear_buffer1 = 1'b1;
        @(negedge ddr3_clk);
        clear_buffer0 = 1'b0;
        clear_buffer1 = 1'b0;
    endtask

    task automatic wait_frame(input int target, input int budget);
        int c = 0;
        while (frames_seen < target && c < budget) begin
            @(negedge ddr3_clk);
            c++;
        end
        chk("frame_timeout", 128'(frames_seen >= target), 128'd1);
    endtask

    // Source FIFO: a beat taken at an edge leaves the head just after that edge.
    always @(posedge ddr3_clk) begin
        #1;
        if (pop_pending && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
        end
        pop_pending = 1'b0;
        refresh();
    end

    // Scoreboard: outputs are stable and inputs show what the next edge will sample.
    always @(negedge ddr3_clk) begin
        #1;
        if (!ddr3_reset_n) begin
            pop_pending = 1'b0;
            mdl_valid   = 2'b00;
            mdl_buf     = 0;
            mdl_burst   = 0;
            mdl_beat    = 0;
            fd_pending  = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            fd_now     = fd_pending;
            fd_pending = 1'b0;
            if (frame_done) frames_seen++;
            if (ddr3_avl_write_req) wr_req_cycles++;
            chk("frame_done", 128'(frame_done), 128'(fd_now));
            chk("buffer0_valid", 128'(buffer0_valid), 128'(mdl_valid[0]));
            chk("buffer1_valid", 128'(buffer1_valid), 128'(mdl_valid[1]));
            chk("fifo_rd", 128'(src_fifo_rd), 128'(ddr3_avl_write_req & ddr3_avl_ready));
            if (prev_stall) begin
                chk("stall_write_req", 128'(ddr3_avl_write_req), 128'd1);
                chk("stall_addr", 128'(ddr3_avl_addr), 128'(prev_addr));
                chk("stall_size", 128'(ddr3_avl_size), 128'(prev_size));
                chk("stall_wdata", ddr3_avl_wdata, prev_wdata);
                chk("stall_bb", 128'(ddr3_avl_burstbegin), 128'(prev_bb));
            end
            if (ddr3_avl_write_req) begin
                chk("size", 128'(ddr3_avl_size), 128'd2);
                chk("be", 128'(ddr3_avl_be), 128'hFFFF);
                if (ddr3_avl_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 128'd1, 128'd0);
                    end else begin
                        exp_word = exp_q.pop_front();
                        exp_addr = (mdl_buf == 1 ? 26'h200 : 26'h100) + 26'(2 * mdl_burst);
                        chk("wdata", ddr3_avl_wdata, exp_word);
                        chk("addr", 128'(ddr3_avl_addr), 128'(exp_addr));
                        chk("burstbegin", 128'(ddr3_avl_burstbegin), 128'(mdl_beat == 0));
                        if (mdl_beat == 0 && mdl_burst == 0) begin
                            chk("no_overwrite", 128'(mdl_valid[mdl_buf]), 128'd0);
                        end
                        if (mdl_beat == 0) addr_log.push_back(ddr3_avl_addr);
                        pop_pending = 1'b1;
                        beats_accepted++;
                        mdl_beat++;
                        if (mdl_beat == 2) begin
                            mdl_beat = 0;
                            mdl_burst++;
                            if (mdl_burst == 2) begin
                                mdl_burst  = 0;
                                fd_pending = 1'b1;
                            end
                        end
                    end
                end
            end
            prev_stall = ddr3_avl_write_req & ~ddr3_avl_ready;
            prev_addr  = ddr3_avl_addr;
            prev_size  = ddr3_avl_size;
            prev_wdata = ddr3_avl_wdata;
            prev_bb    = ddr3_avl_burstbegin;
            nv = mdl_valid;
            if (clear_buffer0) nv[0] = 1'b0;
            if (clear_buffer1) nv[1] = 1'b0;
            if (fd_now) begin
                nv[mdl_buf] = 1'b1;
                mdl_buf     = 1 - mdl_buf;
            end
            mdl_valid = nv;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        int r0;
        ddr3_reset_n   = 1'b1;
        enable         = 1'b0;
        buffer0_offset = 26'h100;
        buffer1_offset = 26'h200;
        clear_buffer0  = 1'b0;
        clear_buffer1  = 1'b0;
        ddr3_avl_ready = 1'b1;
        refresh();
        #3 ddr3_reset_n = 1'b0;
        repeat (3) @(negedge ddr3_clk);
        chk("rst_write_req", 128'(ddr3_avl_write_req), 128'd0);
        chk("rst_burstbegin", 128'(ddr3_avl_burstbegin), 128'd0);
        chk("rst_addr", 128'(ddr3_avl_addr), 128'd0);
        chk("rst_size", 128'(ddr3_avl_size), 128'd0);
        chk("rst_frame_done", 128'(frame_done), 128'd0);
        chk("rst_valids", 128'({buffer1_valid, buffer0_valid}), 128'd0);
        ddr3_reset_n = 1'b1;

        // Frame 1 into buffer 0
        push_words(4);
        enable = 1'b1;
        wait_frame(1, 100);
        repeat (2) @(negedge ddr3_clk);
        chk("f1_bursts", 128'(addr_log.size()), 128'd2);
        chk("f1_addr0", 128'(addr_log[0]), 128'h100);
        chk("f1_addr1", 128'(addr_log[1]), 128'h102);
        chk("f1_buffer0_valid", 128'(buffer0_valid), 128'd1);

        // Frame 2 into buffer 1, then frame 3 must wait for the reader
        push_words(4);
        wait_frame(2, 100);
        repeat (2) @(negedge ddr3_clk);
        chk("f2_addr0", 128'(addr_log[2]), 128'h200);
        chk("f2_addr1", 128'(addr_log[3]), 128'h202);
        chk("f2_buffer1_valid", 128'(buffer1_valid), 128'd1);
        push_words(4);
        c = wr_req_cycles;
        repeat (15) @(negedge ddr3_clk);
        chk("stall_no_write", 128'(wr_req_cycles - c), 128'd0);
        pulse_clear(0);
        wait_frame(3, 100);
        repeat (2) @(negedge ddr3_clk);
        chk("f3_addr0", 128'(addr_log[4]), 128'h100);

        // Clear of a non-valid buffer has no effect
        pulse_clear(1);
        pulse_clear(1);
        @(negedge ddr3_clk);
        chk("clr_nonvalid_b1", 128'(buffer1_valid), 128'd0);
        chk("clr_nonvalid_b0", 128'(buffer0_valid), 128'd1);

        // Burst waits for a full burst of data
        usedw_force = 1;
        refresh();
        push_words(2);
        c = wr_req_cycles;
        repeat (20) @(negedge ddr3_clk);
        chk("low_usedw_no_write", 128'(wr_req_cycles - c), 128'd0);
        usedw_force = -1;
        refresh();
        @(negedge ddr3_clk);
        chk("usedw_release_start", 128'(ddr3_avl_write_req), 128'd1);
        push_words(2);
        wait_frame(4, 100);

        // Ready toggling every cycle; enable dropped mid-frame
        pulse_clear(0);
        push_words(4);
        c = 0;
        while (frames_seen < 5 && c < 200) begin
            @(negedge ddr3_clk);
            ddr3_avl_ready = ~ddr3_avl_ready;
            if (beats_accepted >= 17) enable = 1'b0;
            c++;
        end
        ddr3_avl_ready = 1'b1;
        wait_frame(5, 10);
        chk("beats_total", 128'(beats_accepted), 128'd20);
        pulse_clear(1);
        push_words(4);
        c = wr_req_cycles;
        repeat (10) @(negedge ddr3_clk);
        chk("enable_low_no_start", 128'(wr_req_cycles - c), 128'd0);

        // Reader clear landing on the completion cycle
        enable = 1'b1;
        c = 0;
        while (!frame_done && c < 100) begin
            @(negedge ddr3_clk);
            c++;
        end
        clear_buffer1 = 1'b1;
        @(negedge ddr3_clk);
        clear_buffer1 = 1'b0;
        @(negedge ddr3_clk);
        chk("set_wins_clear", 128'(buffer1_valid), 128'd1);

        // Reset in the middle of the first burst
        pulse_clear(0);
        push_words(4);
        c = 0;
        while (!ddr3_avl_write_req && c < 50) begin
            @(negedge ddr3_clk);
            c++;
        end
        ddr3_reset_n = 1'b0;
        #1;
        chk("mid_rst_write_req", 128'(ddr3_avl_write_req), 128'd0);
        chk("mid_rst_burstbegin", 128'(ddr3_avl_burstbegin), 128'd0);
        chk("mid_rst_addr", 128'(ddr3_avl_addr), 128'd0);
        chk("mid_rst_size", 128'(ddr3_avl_size), 128'd0);
        chk("mid_rst_valids", 128'({buffer1_valid, buffer0_valid}), 128'd0);
        fifo_q.delete();
        exp_q.delete();
        refresh();
        repeat (2) @(negedge ddr3_clk);
        ddr3_reset_n = 1'b1;
        r0 = frames_seen;
        push_words(4);
        wait_frame(r0 + 1, 100);
        repeat (2) @(negedge ddr3_clk);
        chk("post_rst_addr0", 128'(addr_log[addr_log.size() - 2]), 128'h100);
        chk("post_rst_addr1", 128'(addr_log[addr_log.size() - 1]), 128'h102);
        chk("post_rst_buffer0_valid", 128'(buffer0_valid), 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
